// File: rtl/ysyx_22040750_axi_arbiter_pkg.sv
// Shared AXI field widths, burst-size constant and one-hot FSM encodings
// for the icache/dcache to memory AXI arbiter.
package ysyx_22040750_axi_arbiter_pkg;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 64;
  localparam int AXI_LEN_W  = 8;
  localparam int AXI_SIZE_W = 3;

  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_64 = 3'b011;

  // Grant encoding: bit 0 of the arbiter vector is icache, bit 1 is dcache
  localparam logic GNT_IC = 1'b0;
  localparam logic GNT_DC = 1'b1;

  typedef enum logic [2:0] {
    R_IDLE = 3'b001,
    R_AR   = 3'b010,
    R_DATA = 3'b100
  } rd_state_e;

  typedef enum logic [3:0] {
    W_IDLE = 4'b0001,
    W_AW   = 4'b0010,
    W_DATA = 4'b0100,
    W_RESP = 4'b1000
  } wr_state_e;
endpackage

// File: rtl/ysyx_22040750_rr_arb2.sv
// Two-way round-robin grant; combinational, history register lives in parent.
module ysyx_22040750_rr_arb2 (
  input  logic [1:0] i_req,
  input  logic [1:0] i_elig,
  input  logic       i_last_grant,
  output logic [1:0] o_gnt
);
  logic [1:0] w_req;

  assign w_req = i_req & i_elig;

  // On a tie the master that did not win last time goes first
  always_comb begin
    o_gnt = 2'b00;
    case (w_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_last_grant ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end
endmodule

// File: rtl/ysyx_22040750_axi_arbiter.sv
// Merges icache and dcache AXI masters onto one memory port: round-robin
// burst-level read arbitration plus an independent dcache write path.
module ysyx_22040750_axi_arbiter
  import ysyx_22040750_axi_arbiter_pkg::*;
#(
  parameter int ADDR_W    = AXI_ADDR_W,
  parameter int DATA_W    = AXI_DATA_W,
  parameter int LINE_OFFT = 5
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  input  logic [ADDR_W-1:0]     I_ic_araddr,
  input  logic [AXI_LEN_W-1:0]  I_ic_arlen,
  input  logic [AXI_SIZE_W-1:0] I_ic_arsize,
  input  logic                  I_ic_arvalid,
  output logic                  O_ic_arready,
  output logic [DATA_W-1:0]     O_ic_rdata,
  output logic                  O_ic_rvalid,
  output logic                  O_ic_rlast,
  input  logic                  I_ic_rready,
  input  logic [ADDR_W-1:0]     I_dc_araddr,
  input  logic [AXI_LEN_W-1:0]  I_dc_arlen,
  input  logic [AXI_SIZE_W-1:0] I_dc_arsize,
  input  logic                  I_dc_arvalid,
  output logic                  O_dc_arready,
  output logic [DATA_W-1:0]     O_dc_rdata,
  output logic                  O_dc_rvalid,
  output logic                  O_dc_rlast,
  input  logic                  I_dc_rready,
  input  logic [ADDR_W-1:0]     I_dc_awaddr,
  input  logic [AXI_LEN_W-1:0]  I_dc_awlen,
  input  logic [AXI_SIZE_W-1:0] I_dc_awsize,
  input  logic                  I_dc_awvalid,
  output logic                  O_dc_awready,
  input  logic [DATA_W-1:0]     I_dc_wdata,
  input  logic [DATA_W/8-1:0]   I_dc_wstrb,
  input  logic                  I_dc_wlast,
  input  logic                  I_dc_wvalid,
  output logic                  O_dc_wready,
  output logic                  O_dc_bvalid,
  input  logic                  I_dc_bready,
  output logic [ADDR_W-1:0]     O_mem_araddr,
  output logic [AXI_LEN_W-1:0]  O_mem_arlen,
  output logic [AXI_SIZE_W-1:0] O_mem_arsize,
  output logic                  O_mem_arvalid,
  input  logic                  I_mem_arready,
  input  logic [DATA_W-1:0]     I_mem_rdata,
  input  logic                  I_mem_rvalid,
  input  logic                  I_mem_rlast,
  output logic                  O_mem_rready,
  output logic [ADDR_W-1:0]     O_mem_awaddr,
  output logic [AXI_LEN_W-1:0]  O_mem_awlen,
  output logic [AXI_SIZE_W-1:0] O_mem_awsize,
  output logic                  O_mem_awvalid,
  input  logic                  I_mem_awready,
  output logic [DATA_W-1:0]     O_mem_wdata,
  output logic [DATA_W/8-1:0]   O_mem_wstrb,
  output logic                  O_mem_wlast,
  output logic                  O_mem_wvalid,
  input  logic                  I_mem_wready,
  input  logic                  I_mem_bvalid,
  output logic                  O_mem_bready,
  output logic                  O_rlen_err
);
  rd_state_e r_rstate, w_rstate_nxt;
  wr_state_e r_wstate, w_wstate_nxt;

  logic                     r_grant;
  logic                     r_last_grant;
  logic [AXI_LEN_W-1:0]     r_cnt;
  logic                     r_rlen_err;
  logic [ADDR_W-1:LINE_OFFT] r_awline;

  logic [1:0] w_gnt;
  logic       w_ic_elig;
  logic       w_ar_hs;
  logic       w_r_hs;
  logic       w_aw_hs;
  logic       w_w_last_hs;
  logic       w_b_hs;

  // An icache refill must not read a line the dcache is still writing back
  assign w_ic_elig = !((r_wstate != W_IDLE) &&
                       (I_ic_araddr[ADDR_W-1:LINE_OFFT] == r_awline));

  ysyx_22040750_rr_arb2 u_rr_arb2 (
    .i_req        ({I_dc_arvalid, I_ic_arvalid}),
    .i_elig       ({1'b1, w_ic_elig}),
    .i_last_grant (r_last_grant),
    .o_gnt        (w_gnt)
  );

  assign w_ar_hs     = (r_rstate == R_AR) && O_mem_arvalid && I_mem_arready;
  assign w_r_hs      = (r_rstate == R_DATA) && I_mem_rvalid && O_mem_rready;
  assign w_aw_hs     = (r_wstate == W_AW) && I_dc_awvalid && I_mem_awready;
  assign w_w_last_hs = (r_wstate == W_DATA) && I_dc_wvalid && I_mem_wready && I_dc_wlast;
  assign w_b_hs      = (r_wstate == W_RESP) && I_mem_bvalid && I_dc_bready;

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (|w_gnt) w_rstate_nxt = R_AR;
      R_AR:    if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (w_r_hs && I_mem_rlast) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      r_rstate     <= R_IDLE;
      r_grant      <= GNT_IC;
      r_last_grant <= GNT_IC;
      r_cnt        <= '0;
      r_rlen_err   <= 1'b0;
    end else begin
      r_rstate <= w_rstate_nxt;
      if ((r_rstate == R_IDLE) && |w_gnt) r_grant <= w_gnt[1];
      if (w_ar_hs) r_cnt <= r_grant ? I_dc_arlen : I_ic_arlen;
      if (w_r_hs) begin
        r_cnt <= r_cnt - 8'd1;
        // The last beat is expected exactly when the counter has run down
        if (I_mem_rlast != (r_cnt == '0)) r_rlen_err <= 1'b1;
        if (I_mem_rlast) r_last_grant <= r_grant;
      end
    end
  end

  always_comb begin
    O_mem_araddr  = '0;
    O_mem_arlen   = '0;
    O_mem_arsize  = '0;
    O_mem_arvalid = 1'b0;
    O_ic_arready  = 1'b0;
    O_dc_arready  = 1'b0;
    O_mem_rready  = 1'b0;
    O_ic_rdata    = '0;
    O_ic_rvalid   = 1'b0;
    O_ic_rlast    = 1'b0;
    O_dc_rdata    = '0;
    O_dc_rvalid   = 1'b0;
    O_dc_rlast    = 1'b0;
    case (r_rstate)
      R_AR: begin
        O_mem_araddr  = r_grant ? I_dc_araddr  : I_ic_araddr;
        O_mem_arlen   = r_grant ? I_dc_arlen   : I_ic_arlen;
        O_mem_arsize  = r_grant ? I_dc_arsize  : I_ic_arsize;
        O_mem_arvalid = r_grant ? I_dc_arvalid : I_ic_arvalid;
        O_dc_arready  = r_grant && I_mem_arready;
        O_ic_arready  = !r_grant && I_mem_arready;
      end
      R_DATA: begin
        if (r_grant) begin
          O_dc_rdata   = I_mem_rdata;
          O_dc_rvalid  = I_mem_rvalid;
          O_dc_rlast   = I_mem_rlast;
          O_mem_rready = I_dc_rready;
        end else begin
          O_ic_rdata   = I_mem_rdata;
          O_ic_rvalid  = I_mem_rvalid;
          O_ic_rlast   = I_mem_rlast;
          O_mem_rready = I_ic_rready;
        end
      end
      default: ;
    endcase
  end

  assign O_rlen_err = r_rlen_err;

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (I_dc_awvalid) w_wstate_nxt = W_AW;
      W_AW:    if (w_aw_hs) w_wstate_nxt = W_DATA;
      W_DATA:  if (w_w_last_hs) w_wstate_nxt = W_RESP;
      W_RESP:  if (w_b_hs) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      r_wstate <= W_IDLE;
      r_awline <= '0;
    end else begin
      r_wstate <= w_wstate_nxt;
      if ((r_wstate == W_IDLE) && I_dc_awvalid)
        r_awline <= I_dc_awaddr[ADDR_W-1:LINE_OFFT];
    end
  end

  always_comb begin
    O_mem_awaddr  = '0;
    O_mem_awlen   = '0;
    O_mem_awsize  = '0;
    O_mem_awvalid = 1'b0;
    O_dc_awready  = 1'b0;
    O_mem_wdata   = '0;
    O_mem_wstrb   = '0;
    O_mem_wlast   = 1'b0;
    O_mem_wvalid  = 1'b0;
    O_dc_wready   = 1'b0;
    O_dc_bvalid   = 1'b0;
    O_mem_bready  = 1'b0;
    case (r_wstate)
      W_AW: begin
        O_mem_awaddr  = I_dc_awaddr;
        O_mem_awlen   = I_dc_awlen;
        O_mem_awsize  = I_dc_awsize;
        O_mem_awvalid = I_dc_awvalid;
        O_dc_awready  = I_mem_awready;
      end
      W_DATA: begin
        O_mem_wdata  = I_dc_wdata;
        O_mem_wstrb  = I_dc_wstrb;
        O_mem_wlast  = I_dc_wlast;
        O_mem_wvalid = I_dc_wvalid;
        O_dc_wready  = I_mem_wready;
      end
      W_RESP: begin
        O_dc_bvalid  = I_mem_bvalid;
        O_mem_bready = I_dc_bready;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ysyx_22040750_axi_arbiter.sv
// Directed bench for the AXI arbiter: arbitration order, line hazard,
// overlapped read/write, beat-count error and mid-burst reset.
module tb_ysyx_22040750_axi_arbiter;
  import ysyx_22040750_axi_arbiter_pkg::*;

  localparam logic [63:0] RD_BASE = 64'h1111_2222_3333_0000;
  localparam logic [63:0] WD_BASE = 64'hCAFE_0000_BEEF_0000;

  logic        I_clk, I_rst;
  logic [31:0] I_ic_araddr;  logic [7:0] I_ic_arlen;  logic [2:0] I_ic_arsize;  logic I_ic_arvalid;
  logic        O_ic_arready; logic [63:0] O_ic_rdata; logic O_ic_rvalid, O_ic_rlast; logic I_ic_rready;
  logic [31:0] I_dc_araddr;  logic [7:0] I_dc_arlen;  logic [2:0] I_dc_arsize;  logic I_dc_arvalid;
  logic        O_dc_arready; logic [63:0] O_dc_rdata; logic O_dc_rvalid, O_dc_rlast; logic I_dc_rready;
  logic [31:0] I_dc_awaddr;  logic [7:0] I_dc_awlen;  logic [2:0] I_dc_awsize;  logic I_dc_awvalid;
  logic        O_dc_awready;
  logic [63:0] I_dc_wdata;   logic [7:0] I_dc_wstrb;  logic I_dc_wlast, I_dc_wvalid;
  logic        O_dc_wready, O_dc_bvalid, I_dc_bready;
  logic [31:0] O_mem_araddr; logic [7:0] O_mem_arlen; logic [2:0] O_mem_arsize; logic O_mem_arvalid;
  logic        I_mem_arready;
  logic [63:0] I_mem_rdata;  logic I_mem_rvalid, I_mem_rlast, O_mem_rready;
  logic [31:0] O_mem_awaddr; logic [7:0] O_mem_awlen; logic [2:0] O_mem_awsize; logic O_mem_awvalid;
  logic        I_mem_awready;
  logic [63:0] O_mem_wdata;  logic [7:0] O_mem_wstrb; logic O_mem_wlast, O_mem_wvalid;
  logic        I_mem_wready, I_mem_bvalid, O_mem_bready, O_rlen_err;

  int checks = 0;
  int errors = 0;

  ysyx_22040750_axi_arbiter dut (
    .I_clk(I_clk), .I_rst(I_rst),
    .I_ic_araddr(I_ic_araddr), .I_ic_arlen(I_ic_arlen), .I_ic_arsize(I_ic_arsize),
    .I_ic_arvalid(I_ic_arvalid), .O_ic_arready(O_ic_arready),
    .O_ic_rdata(O_ic_rdata), .O_ic_rvalid(O_ic_rvalid), .O_ic_rlast(O_ic_rlast),
    .I_ic_rready(I_ic_rready),
    .I_dc_araddr(I_dc_araddr), .I_dc_arlen(I_dc_arlen), .I_dc_arsize(I_dc_arsize),
    .I_dc_arvalid(I_dc_arvalid), .O_dc_arready(O_dc_arready),
    .O_dc_rdata(O_dc_rdata), .O_dc_rvalid(O_dc_rvalid), .O_dc_rlast(O_dc_rlast),
    .I_dc_rready(I_dc_rready),
    .I_dc_awaddr(I_dc_awaddr), .I_dc_awlen(I_dc_awlen), .I_dc_awsize(I_dc_awsize),
    .I_dc_awvalid(I_dc_awvalid), .O_dc_awready(O_dc_awready),
    .I_dc_wdata(I_dc_wdata), .I_dc_wstrb(I_dc_wstrb), .I_dc_wlast(I_dc_wlast),
    .I_dc_wvalid(I_dc_wvalid), .O_dc_wready(O_dc_wready),
    .O_dc_bvalid(O_dc_bvalid), .I_dc_bready(I_dc_bready),
    .O_mem_araddr(O_mem_araddr), .O_mem_arlen(O_mem_arlen), .O_mem_arsize(O_mem_arsize),
    .O_mem_arvalid(O_mem_arvalid), .I_mem_arready(I_mem_arready),
    .I_mem_rdata(I_mem_rdata), .I_mem_rvalid(I_mem_rvalid), .I_mem_rlast(I_mem_rlast),
    .O_mem_rready(O_mem_rready),
    .O_mem_awaddr(O_mem_awaddr), .O_mem_awlen(O_mem_awlen), .O_mem_awsize(O_mem_awsize),
    .O_mem_awvalid(O_mem_awvalid), .I_mem_awready(I_mem_awready),
    .O_mem_wdata(O_mem_wdata), .O_mem_wstrb(O_mem_wstrb), .O_mem_wlast(O_mem_wlast),
    .O_mem_wvalid(O_mem_wvalid), .I_mem_wready(I_mem_wready),
    .I_mem_bvalid(I_mem_bvalid), .O_mem_bready(O_mem_bready),
    .O_rlen_err(O_rlen_err)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge I_clk);
  endtask

  // Arbitration cycle: nothing reaches memory yet
  task automatic grant_cycle();
    #1;
    chk("grant_bubble_arvalid", O_mem_arvalid, 1'b0);
    chk("grant_bubble_arready", O_ic_arready | O_dc_arready, 1'b0);
    tick();
  endtask

  task automatic ar_phase(input bit dc, input logic [31:0] addr, input logic [7:0] len);
    I_mem_arready = 1'b1;
    #1;
    chk("ar_valid", O_mem_arvalid, 1'b1);
    chk("ar_addr", O_mem_araddr, addr);
    chk("ar_len", O_mem_arlen, len);
    chk("ar_size", O_mem_arsize, AXI_SIZE_64);
    chk("ar_ready_granted", dc ? O_dc_arready : O_ic_arready, 1'b1);
    chk("ar_ready_other", dc ? O_ic_arready : O_dc_arready, 1'b0);
    tick();
    I_mem_arready = 1'b0;
    if (dc) I_dc_arvalid = 1'b0; else I_ic_arvalid = 1'b0;
  endtask

  task automatic r_phase(input bit dc, input int n, input int last_idx);
    for (int b = 0; b < n; b++) begin
      I_mem_rvalid = 1'b1;
      I_mem_rdata  = RD_BASE + 64'(b);
      I_mem_rlast  = (b == last_idx);
      I_dc_rready  = dc;
      I_ic_rready  = !dc;
      #1;
      chk("r_valid", dc ? O_dc_rvalid : O_ic_rvalid, 1'b1);
      chk("r_data", dc ? O_dc_rdata : O_ic_rdata, RD_BASE + 64'(b));
      chk("r_last", dc ? O_dc_rlast : O_ic_rlast, (b == last_idx));
      chk("r_valid_other", dc ? O_ic_rvalid : O_dc_rvalid, 1'b0);
      chk("r_data_other", dc ? O_ic_rdata : O_dc_rdata, 64'd0);
      chk("r_ready", O_mem_rready, 1'b1);
      tick();
    end
    I_mem_rvalid = 1'b0; I_mem_rlast = 1'b0; I_mem_rdata = '0;
    I_dc_rready = 1'b0; I_ic_rready = 1'b0;
  endtask

  task automatic set_ic_ar(input logic [31:0] a, input logic [7:0] l);
    I_ic_araddr = a; I_ic_arlen = l; I_ic_arsize = AXI_SIZE_64; I_ic_arvalid = 1'b1;
  endtask

  task automatic set_dc_ar(input logic [31:0] a, input logic [7:0] l);
    I_dc_araddr = a; I_dc_arlen = l; I_dc_arsize = AXI_SIZE_64; I_dc_arvalid = 1'b1;
  endtask

  initial begin
    I_rst = 1'b1;
    I_ic_araddr = '0; I_ic_arlen = '0; I_ic_arsize = '0; I_ic_arvalid = 1'b0; I_ic_rready = 1'b0;
    I_dc_araddr = '0; I_dc_arlen = '0; I_dc_arsize = '0; I_dc_arvalid = 1'b0; I_dc_rready = 1'b0;
    I_dc_awaddr = '0; I_dc_awlen = '0; I_dc_awsize = '0; I_dc_awvalid = 1'b0;
    I_dc_wdata = '0; I_dc_wstrb = '0; I_dc_wlast = 1'b0; I_dc_wvalid = 1'b0; I_dc_bready = 1'b0;
    I_mem_arready = 1'b0; I_mem_rdata = '0; I_mem_rvalid = 1'b0; I_mem_rlast = 1'b0;
    I_mem_awready = 1'b0; I_mem_wready = 1'b0; I_mem_bvalid = 1'b0;

    // Reset state, with memory-side inputs wiggled to show outputs are gated
    tick(); tick();
    I_mem_rvalid = 1'b1; I_mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF; I_mem_arready = 1'b1;
    I_mem_bvalid = 1'b1; I_mem_wready = 1'b1; I_mem_awready = 1'b1;
    #1;
    chk("rst_mem_arvalid", O_mem_arvalid, 1'b0);
    chk("rst_ic_rvalid", O_ic_rvalid, 1'b0);
    chk("rst_ic_rdata", O_ic_rdata, 64'd0);
    chk("rst_dc_arready", O_dc_arready, 1'b0);
    chk("rst_dc_bvalid", O_dc_bvalid, 1'b0);
    chk("rst_dc_wready", O_dc_wready, 1'b0);
    chk("rst_mem_awvalid", O_mem_awvalid, 1'b0);
    chk("rst_rlen_err", O_rlen_err, 1'b0);
    I_mem_rvalid = 1'b0; I_mem_rdata = '0; I_mem_arready = 1'b0;
    I_mem_bvalid = 1'b0; I_mem_wready = 1'b0; I_mem_awready = 1'b0;
    tick();
    I_rst = 1'b0;
    tick();

    // Simultaneous request after reset: dcache first, then icache
    set_ic_ar(32'h8000_0100, 8'd1);
    set_dc_ar(32'h8000_0200, 8'd1);
    grant_cycle();
    ar_phase(1'b1, 32'h8000_0200, 8'd1);
    r_phase(1'b1, 2, 1);
    grant_cycle();
    ar_phase(1'b0, 32'h8000_0100, 8'd1);
    r_phase(1'b0, 2, 1);

    // Icache-only 4-beat burst
    set_ic_ar(32'h8000_0000, 8'd3);
    grant_cycle();
    ar_phase(1'b0, 32'h8000_0000, 8'd3);
    r_phase(1'b0, 4, 3);
    #1;
    chk("ic_burst_idle_arvalid", O_mem_arvalid, 1'b0);
    chk("ic_burst_no_err", O_rlen_err, 1'b0);

    // Dcache-only read leaves last_grant at dcache; next tie goes icache then dcache
    set_dc_ar(32'h8000_0300, 8'd0);
    grant_cycle();
    ar_phase(1'b1, 32'h8000_0300, 8'd0);
    r_phase(1'b1, 1, 0);
    set_ic_ar(32'h8000_0400, 8'd0);
    set_dc_ar(32'h8000_0500, 8'd0);
    grant_cycle();
    ar_phase(1'b0, 32'h8000_0400, 8'd0);
    r_phase(1'b0, 1, 0);
    grant_cycle();
    ar_phase(1'b1, 32'h8000_0500, 8'd0);
    r_phase(1'b1, 1, 0);

    // Same-line hazard: icache read held until the writeback response
    I_dc_awaddr = 32'h8000_1020; I_dc_awlen = 8'd0; I_dc_awsize = AXI_SIZE_64; I_dc_awvalid = 1'b1;
    #1;
    chk("aw_idle_awready", O_dc_awready, 1'b0);
    chk("aw_idle_awvalid", O_mem_awvalid, 1'b0);
    tick();
    set_ic_ar(32'h8000_1028, 8'd0);
    I_mem_awready = 1'b1;
    #1;
    chk("aw_valid", O_mem_awvalid, 1'b1);
    chk("aw_addr", O_mem_awaddr, 32'h8000_1020);
    chk("aw_ready", O_dc_awready, 1'b1);
    tick();
    I_dc_awvalid = 1'b0; I_mem_awready = 1'b0;
    I_dc_wvalid = 1'b1; I_dc_wdata = WD_BASE; I_dc_wstrb = 8'h0F; I_dc_wlast = 1'b1; I_mem_wready = 1'b1;
    #1;
    chk("hz_w_valid", O_mem_wvalid, 1'b1);
    chk("hz_w_data", O_mem_wdata, WD_BASE);
    chk("hz_w_strb", O_mem_wstrb, 8'h0F);
    chk("hz_w_ready", O_dc_wready, 1'b1);
    chk("hz_held_w", O_mem_arvalid, 1'b0);
    tick();
    I_dc_wvalid = 1'b0; I_dc_wlast = 1'b0; I_mem_wready = 1'b0;
    I_mem_bvalid = 1'b1; I_dc_bready = 1'b1;
    #1;
    chk("hz_b_valid", O_dc_bvalid, 1'b1);
    chk("hz_b_ready", O_mem_bready, 1'b1);
    chk("hz_held_b", O_mem_arvalid, 1'b0);
    tick();
    I_mem_bvalid = 1'b0; I_dc_bready = 1'b0;
    #1;
    chk("hz_b_done", O_dc_bvalid, 1'b0);
    grant_cycle();
    ar_phase(1'b0, 32'h8000_1028, 8'd0);
    r_phase(1'b0, 1, 0);

    // Different line during a writeback is granted at once
    I_dc_awaddr = 32'h8000_1020; I_dc_awvalid = 1'b1;
    tick();
    set_ic_ar(32'h8000_2000, 8'd0);
    grant_cycle();
    ar_phase(1'b0, 32'h8000_2000, 8'd0);
    r_phase(1'b0, 1, 0);
    I_mem_awready = 1'b1;
    #1;
    chk("nohz_aw_valid", O_mem_awvalid, 1'b1);
    tick();
    I_dc_awvalid = 1'b0; I_mem_awready = 1'b0;
    I_dc_wvalid = 1'b1; I_dc_wlast = 1'b1; I_mem_wready = 1'b1;
    tick();
    I_dc_wvalid = 1'b0; I_dc_wlast = 1'b0; I_mem_wready = 1'b0;
    I_mem_bvalid = 1'b1; I_dc_bready = 1'b1;
    tick();
    I_mem_bvalid = 1'b0; I_dc_bready = 1'b0;

    // Overlapped dcache read and write, 4 beats each
    set_dc_ar(32'h8000_3000, 8'd3);
    I_dc_awaddr = 32'h8000_4000; I_dc_awlen = 8'd3; I_dc_awvalid = 1'b1;
    tick();
    I_mem_arready = 1'b1; I_mem_awready = 1'b1;
    #1;
    chk("ov_ar_valid", O_mem_arvalid, 1'b1);
    chk("ov_ar_addr", O_mem_araddr, 32'h8000_3000);
    chk("ov_aw_valid", O_mem_awvalid, 1'b1);
    chk("ov_aw_addr", O_mem_awaddr, 32'h8000_4000);
    chk("ov_aw_len", O_mem_awlen, 8'd3);
    tick();
    I_mem_arready = 1'b0; I_mem_awready = 1'b0; I_dc_arvalid = 1'b0; I_dc_awvalid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      I_mem_rvalid = 1'b1; I_mem_rdata = RD_BASE + 64'(b); I_mem_rlast = (b == 3); I_dc_rready = 1'b1;
      I_dc_wvalid = 1'b1; I_dc_wdata = WD_BASE + 64'(b); I_dc_wstrb = 8'hFF; I_dc_wlast = (b == 3);
      I_mem_wready = 1'b1;
      #1;
      chk("ov_r_valid", O_dc_rvalid, 1'b1);
      chk("ov_r_data", O_dc_rdata, RD_BASE + 64'(b));
      chk("ov_ic_rvalid", O_ic_rvalid, 1'b0);
      chk("ov_w_data", O_mem_wdata, WD_BASE + 64'(b));
      chk("ov_w_last", O_mem_wlast, (b == 3));
      tick();
    end
    I_mem_rvalid = 1'b0; I_mem_rlast = 1'b0; I_dc_rready = 1'b0;
    I_dc_wvalid = 1'b0; I_dc_wlast = 1'b0; I_mem_wready = 1'b0;
    I_mem_bvalid = 1'b1; I_dc_bready = 1'b1;
    #1;
    chk("ov_b_valid", O_dc_bvalid, 1'b1);
    chk("ov_w_done", O_mem_wvalid, 1'b0);
    tick();
    I_mem_bvalid = 1'b0; I_dc_bready = 1'b0;

    // Early rlast: sticky error, FSM still returns to idle
    set_dc_ar(32'h8000_5000, 8'd3);
    grant_cycle();
    ar_phase(1'b1, 32'h8000_5000, 8'd3);
    #1;
    chk("err_before", O_rlen_err, 1'b0);
    r_phase(1'b1, 3, 2);
    #1;
    chk("err_set", O_rlen_err, 1'b1);
    set_ic_ar(32'h8000_6000, 8'd0);
    grant_cycle();
    ar_phase(1'b0, 32'h8000_6000, 8'd0);
    r_phase(1'b0, 1, 0);
    #1;
    chk("err_sticky", O_rlen_err, 1'b1);

    // Reset during beat 2 of an icache burst
    set_ic_ar(32'h8000_7000, 8'd3);
    grant_cycle();
    ar_phase(1'b0, 32'h8000_7000, 8'd3);
    r_phase(1'b0, 1, 9);
    I_mem_rvalid = 1'b1; I_mem_rdata = RD_BASE; I_ic_rready = 1'b1;
    #1;
    chk("mid_rvalid_before", O_ic_rvalid, 1'b1);
    I_rst = 1'b1;
    #1;
    chk("mid_rst_rvalid", O_ic_rvalid, 1'b0);
    chk("mid_rst_rdata", O_ic_rdata, 64'd0);
    chk("mid_rst_rready", O_mem_rready, 1'b0);
    chk("mid_rst_err", O_rlen_err, 1'b0);
    tick();
    I_rst = 1'b0;
    I_mem_rvalid = 1'b0; I_mem_rdata = '0; I_ic_rready = 1'b0;
    set_ic_ar(32'h8000_8000, 8'd0);
    set_dc_ar(32'h8000_9000, 8'd0);
    grant_cycle();
    ar_phase(1'b1, 32'h8000_9000, 8'd0);
    r_phase(1'b1, 1, 0);
    grant_cycle();
    ar_phase(1'b0, 32'h8000_8000, 8'd0);
    r_phase(1'b0, 1, 0);
    #1;
    chk("post_rst_no_err", O_rlen_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
